sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single SDRAM controller command port between the capture (write) path, the playback (read) path and periodic auto-refresh. Sits between the sample front-end / PWM playback logic and the SDRAM controller, in the 100 MHz controller clock domain. Refresh has absolute priority. Read and write requesters alternate round-robin when both are pending. A sticky flag reports missed refresh deadlines.

## Interface
Parameters:
- ADDR_W, 25, SDRAM word address width (2 bank + 13 row + 10 col)
- DATA_W, 16, SDRAM data width
- REFRESH_INTERVAL, 780, cycles between refresh ticks (7.8 µs at 100 MHz)

Ports:
- CLK  in  1  controller clock (100 MHz); one clock
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write request, level, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req
- wr_data  in  DATA_W  write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse: write accepted by controller
- rd_req  in  1  read request, level, held until rd_ack
- rd_addr  in  ADDR_W  read address, stable while rd_req
- rd_ack  out  1  one-cycle pulse: read accepted by controller
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  DATA_W  registered read data
- ctl_cmd  out  2  0 NOP, 1 WRITE, 2 READ, 3 REFRESH
- ctl_addr  out  ADDR_W  command address
- ctl_wdata  out  DATA_W  write data to controller
- ctl_start  out  1  command valid; held until accepted
- ctl_ready  in  1  controller can accept; accepted when ctl_start & ctl_ready
- ctl_done  in  1  one-cycle pulse: current command complete
- ctl_rdata  in  DATA_W  read data, valid with ctl_done on READ
- refresh_miss  out  1  sticky: a refresh tick arrived while one was still pending

## Operation
- States: IDLE, CMD, WAIT.
- IDLE: choose a grant in priority order. (1) Refresh, if refresh_pending or a tick occurs this cycle. (2) Read/write: if only one requests, grant it. If both request, grant the opposite of last_grant. Load ctl_cmd/addr/wdata and go to CMD. With no request, stay in IDLE and keep ctl_cmd = NOP.
- CMD: ctl_start = 1 and command fields held. When ctl_ready = 1: pulse wr_ack or rd_ack for R/W; on REFRESH, clear refresh_pending unless a new tick arrives in the same cycle. Update last_grant for R/W only, then go to WAIT.
- WAIT: on ctl_done, go to IDLE. If the command was READ, register ctl_rdata into rd_data and pulse rd_valid next cycle.
- Refresh timer: down-counter reloads to REFRESH_INTERVAL-1. At 0 it issues a tick, sets refresh_pending and reloads. If refresh_pending is already set at a tick, set refresh_miss; it stays set until reset.
- Requests that drop before ack: ignored if dropped while IDLE. Once in CMD, the command completes regardless.
- Reset (any time, including mid-command): state IDLE, all outputs 0, ctl_cmd NOP, refresh_pending 0, timer reloaded, last_grant = READ so the first contended grant is WRITE. The controller shares reset_n, so abandoned commands are not resumed.

## Timing
- Grant decision on the IDLE edge. ctl_start rises the cycle after the request is sampled, so the minimum request-to-ctl_start latency is 1 cycle.
- wr_ack/rd_ack are asserted in the same cycle that ctl_start & ctl_ready is sampled high.
- rd_valid comes 1 cycle after ctl_done.
- Back-to-back: a new grant can be made in the cycle after ctl_done. Minimum spacing between ctl_start assertions is 3 cycles.
- Worst-case grant wait for a requester under contention: one refresh plus one command of the other port.

## Structure
- Package drfm_sdram_pkg:
  - command encoding constants (CMD_NOP, CMD_WRITE, CMD_READ, CMD_REFRESH)
  - state encoding
  - default ADDR_W, DATA_W, REFRESH_INTERVAL
- Sub-module sdram_refresh_timer:
  - inputs: CLK, reset_n, clear
  - outputs: tick, pending, miss
- Arbiter FSM and command registers stay in sdram_port_arbiter.

## Test plan
- Single write: wr_req with addr 0x0000123, data 0xBEEF; ctl_ready tied 1; ctl_done 4 cycles later. Expect ctl_cmd = 1 with correct addr/data, exactly one wr_ack, return to IDLE.
- Single read: rd_req addr 0x1ABCDEF; ctl_done with ctl_rdata 0x5A5A. Expect one rd_ack, then rd_valid with rd_data 0x5A5A exactly 1 cycle after ctl_done.
- Contention: wr_req and rd_req held continuously for 6 grants. Grant order is W, R, W, R, W, R from reset.
- Refresh priority: a tick lands while a read is in WAIT and a write is pending. After ctl_done the next command is REFRESH, then the write. Refresh ticks are spaced exactly 780 cycles.
- Refresh miss: hold ctl_ready = 0 for more than 780 cycles after a refresh is granted. Expect refresh_miss = 1 on the second tick, and it stays 1.
- Reset mid-op: assert reset_n = 0 during CMD with ctl_ready = 0. All outputs go to 0 asynchronously, and no ack is issued. After release, the first contended grant is WRITE.

Source files
------------

// File: rtl/drfm_sdram_pkg.sv
// drfm_sdram_pkg: command encodings, arbiter states and default sizes shared by the SDRAM port arbiter
package drfm_sdram_pkg;
    localparam logic [1:0] CMD_NOP     = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_REFRESH = 2'd3;

    localparam int DEF_ADDR_W           = 25;
    localparam int DEF_DATA_W           = 16;
    localparam int DEF_REFRESH_INTERVAL = 780;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT} state_t;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh tick with pending flag and sticky missed-deadline flag
//   CLK, reset_n : clock, asynchronous active-low reset
//   clear        : the pending refresh has been accepted by the controller
//   tick         : one-cycle pulse every REFRESH_INTERVAL cycles
//   pending      : a refresh is owed to the controller
//   miss         : sticky, a tick arrived while a refresh was still owed
module sdram_refresh_timer
    import drfm_sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clear,
    output logic tick,
    output logic pending,
    output logic miss
);
    localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pending_q, pending_d, miss_q, miss_d;

    always_comb begin
        tick      = cnt_q == '0;
        cnt_d     = tick ? RELOAD : cnt_q - 1'b1;
        // a tick landing on the clear cycle re-arms the flag
        pending_d = tick | (pending_q & ~clear);
        miss_d    = miss_q | (tick & pending_q);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
        end
    end

    assign pending = pending_q;
    assign miss    = miss_q;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command port between write, read and auto-refresh
//   wr_req/wr_addr/wr_data -> wr_ack     : capture path, level request held until ack
//   rd_req/rd_addr -> rd_ack/rd_valid/rd_data : playback path, data registered one cycle after ctl_done
//   ctl_cmd/ctl_addr/ctl_wdata/ctl_start : command to controller, accepted on ctl_start & ctl_ready
//   ctl_done/ctl_rdata                   : completion pulse and read data from controller
//   refresh_miss                         : sticky missed refresh deadline
module sdram_port_arbiter
    import drfm_sdram_pkg::*;
#(
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int DATA_W           = DEF_DATA_W,
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        ctl_cmd,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    output logic              ctl_start,
    input  logic              ctl_ready,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic              refresh_miss
);
    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic              last_rd_q, last_rd_d, rd_valid_q, rd_valid_d;
    logic              tick, pending, accept, grant_rd, refresh_clear;

    sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
        .CLK     (CLK),
        .reset_n (reset_n),
        .clear   (refresh_clear),
        .tick    (tick),
        .pending (pending),
        .miss    (refresh_miss)
    );

    assign accept        = (state_q == ST_CMD) & ctl_ready;
    assign refresh_clear = accept & (cmd_q == CMD_REFRESH);
    // under contention the port not served last wins
    assign grant_rd      = rd_req & (~wr_req | ~last_rd_q);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_rd_d  = last_rd_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending | tick) begin
                    cmd_d   = CMD_REFRESH;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = ST_CMD;
                end else if (wr_req | rd_req) begin
                    cmd_d   = grant_rd ? CMD_READ : CMD_WRITE;
                    addr_d  = grant_rd ? rd_addr : wr_addr;
                    wdata_d = grant_rd ? '0 : wr_data;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ctl_ready) begin
                    state_d   = ST_WAIT;
                    last_rd_d = (cmd_q == CMD_REFRESH) ? last_rd_q : (cmd_q == CMD_READ);
                end
            end
            ST_WAIT: begin
                if (ctl_done) begin
                    state_d    = ST_IDLE;
                    cmd_d      = CMD_NOP;
                    rd_valid_d = cmd_q == CMD_READ;
                    rd_data_d  = (cmd_q == CMD_READ) ? ctl_rdata : rd_data_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_rd_q  <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_rd_q  <= last_rd_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign ctl_start = state_q == ST_CMD;
    assign ctl_cmd   = cmd_q;
    assign ctl_addr  = addr_q;
    assign ctl_wdata = wdata_q;
    assign wr_ack    = accept & (cmd_q == CMD_WRITE);
    assign rd_ack    = accept & (cmd_q == CMD_READ);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scoreboard bench for the SDRAM port arbiter
module tb_sdram_port_arbiter;
    import drfm_sdram_pkg::*;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int RI = 780;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0, ctl_ready = 1'b1;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          ctl_done = 1'b0;
    logic [DW-1:0] ctl_rdata = '0;
    logic          wr_ack, rd_ack, rd_valid, ctl_start, refresh_miss;
    logic [DW-1:0] rd_data, ctl_wdata;
    logic [1:0]    ctl_cmd;
    logic [AW-1:0] ctl_addr;

    exp_t          exp_q[$];
    int            vectors = 0, miscompares = 0;
    int            cyc = 0, done_cnt = 0, done_lat = 4, rd_count = 0, ref_t = 0, t2 = 0;
    logic [1:0]    cur_cmd = CMD_NOP;
    logic          rv_due = 1'b0;
    logic [DW-1:0] rv_data = '0, rdata_val = 16'h5A5A;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(RI)) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .ctl_cmd      (ctl_cmd),
        .ctl_addr     (ctl_addr),
        .ctl_wdata    (ctl_wdata),
        .ctl_start    (ctl_start),
        .ctl_ready    (ctl_ready),
        .ctl_done     (ctl_done),
        .ctl_rdata    (ctl_rdata),
        .refresh_miss (refresh_miss)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back(exp_t'{cmd: c, addr: a, data: d});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_q(input int left, input int limit, input string tag);
        int i = 0;
        while (exp_q.size() > left && i < limit) begin
            step(1);
            i++;
        end
        chk(tag, 32'(exp_q.size()), 32'(left));
    endtask

    task automatic wait_idle();
        int i = 0;
        while (done_cnt > 0 && i < 200) begin
            step(1);
            i++;
        end
        step(2);
    endtask

    // controller model and scoreboard consumer, sampled on the falling edge
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            done_cnt  = 0;
            rv_due    = 1'b0;
            ctl_done  = 1'b0;
            ctl_rdata = 16'hDEAD;
        end else begin
            if (rv_due || rd_valid) begin
                chk("rd_valid", 32'(rd_valid), 32'(rv_due));
                if (rv_due) chk("rd_data", 32'(rd_data), 32'(rv_data));
            end
            rv_due    = 1'b0;
            ctl_done  = 1'b0;
            ctl_rdata = 16'hDEAD;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    ctl_done = 1'b1;
                    if (cur_cmd == CMD_READ) begin
                        ctl_rdata = rdata_val + 16'(rd_count);
                        rd_count++;
                        rv_due  = 1'b1;
                        rv_data = ctl_rdata;
                    end
                end
            end
            if (ctl_start && ctl_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 32'(ctl_cmd), 32'(CMD_NOP));
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", 32'(ctl_cmd), 32'(e.cmd));
                    if (e.cmd != CMD_REFRESH) chk("addr", 32'(ctl_addr), 32'(e.addr));
                    if (e.cmd == CMD_WRITE) chk("wdata", 32'(ctl_wdata), 32'(e.data));
                    chk("wr_ack", 32'(wr_ack), 32'(e.cmd == CMD_WRITE));
                    chk("rd_ack", 32'(rd_ack), 32'(e.cmd == CMD_READ));
                    if (e.cmd == CMD_REFRESH) ref_t = cyc;
                end
                cur_cmd  = ctl_cmd;
                done_cnt = done_lat;
            end else if (wr_ack || rd_ack) begin
                chk("stray_ack", {30'd0, wr_ack, rd_ack}, 0);
            end
        end
    end

    initial begin
        int i;
        // reset state
        step(3);
        chk("rst_start", 32'(ctl_start), 0);
        chk("rst_cmd", 32'(ctl_cmd), 32'(CMD_NOP));
        chk("rst_addr", 32'(ctl_addr), 0);
        chk("rst_acks", {30'd0, wr_ack, rd_ack}, 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_miss", 32'(refresh_miss), 0);
        reset_n = 1'b1;
        step(2);

        // single write, one-cycle request-to-start latency
        wr_addr = 25'h0000123;
        wr_data = 16'hBEEF;
        wr_req  = 1'b1;
        push(CMD_WRITE, 25'h0000123, 16'hBEEF);
        step(1);
        chk("wr_start_latency", 32'(ctl_start), 1);
        wait_q(0, 10, "wr_grant_timeout");
        wr_req = 1'b0;
        wait_idle();
        chk("idle_cmd", 32'(ctl_cmd), 32'(CMD_NOP));
        chk("idle_start", 32'(ctl_start), 0);

        // single read
        rd_addr = 25'h1ABCDEF;
        rd_req  = 1'b1;
        push(CMD_READ, 25'h1ABCDEF, '0);
        wait_q(0, 10, "rd_grant_timeout");
        rd_req = 1'b0;
        wait_idle();
        chk("rd_data_hold", 32'(rd_data), 32'h5A5A);

        // contention: W,R,W,R,W,R
        wr_addr = 25'h0001000;
        wr_data = 16'h1111;
        rd_addr = 25'h0002000;
        for (int k = 0; k < 3; k++) begin
            push(CMD_WRITE, 25'h0001000, 16'h1111);
            push(CMD_READ, 25'h0002000, '0);
        end
        wr_req = 1'b1;
        rd_req = 1'b1;
        wait_q(0, 100, "contention_timeout");
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_idle();

        // refresh priority: tick lands while a read sits in WAIT with a write pending
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(730);
        done_lat = 80;
        rd_addr  = 25'h0333333;
        rd_req   = 1'b1;
        push(CMD_READ, 25'h0333333, '0);
        wait_q(0, 10, "prio_rd_timeout");
        rd_req   = 1'b0;
        done_lat = 4;
        step(5);
        wr_addr = 25'h0444444;
        wr_data = 16'hC0DE;
        wr_req  = 1'b1;
        push(CMD_REFRESH, '0, '0);
        push(CMD_WRITE, 25'h0444444, 16'hC0DE);
        wait_q(0, 200, "prio_timeout");
        wr_req = 1'b0;
        wait_idle();
        chk("no_miss_yet", 32'(refresh_miss), 0);

        // idle refresh spacing
        push(CMD_REFRESH, '0, '0);
        wait_q(0, 900, "refresh2_timeout");
        t2 = ref_t;
        wait_idle();
        push(CMD_REFRESH, '0, '0);
        wait_q(0, 900, "refresh3_timeout");
        chk("refresh_spacing", 32'(ref_t - t2), 32'(RI));
        wait_idle();

        // refresh miss: controller stalls a granted refresh past the next tick
        ctl_ready = 1'b0;
        i = 0;
        while (ctl_start !== 1'b1 && i < 900) begin
            step(1);
            i++;
        end
        chk("stall_start", 32'(ctl_start), 1);
        chk("stall_cmd", 32'(ctl_cmd), 32'(CMD_REFRESH));
        step(770);
        chk("miss_before_tick", 32'(refresh_miss), 0);
        chk("stall_held", 32'(ctl_start), 1);
        step(20);
        chk("miss_after_tick", 32'(refresh_miss), 1);
        push(CMD_REFRESH, '0, '0);
        ctl_ready = 1'b1;
        wait_q(0, 5, "stall_release_timeout");
        wait_idle();
        step(20);
        chk("miss_sticky", 32'(refresh_miss), 1);

        // reset during CMD with controller not ready
        ctl_ready = 1'b0;
        wr_addr   = 25'h1555555;
        wr_data   = 16'hA5A5;
        wr_req    = 1'b1;
        step(1);
        chk("mid_start", 32'(ctl_start), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_start", 32'(ctl_start), 0);
        chk("async_cmd", 32'(ctl_cmd), 32'(CMD_NOP));
        chk("async_addr", 32'(ctl_addr), 0);
        chk("async_wdata", 32'(ctl_wdata), 0);
        chk("async_miss", 32'(refresh_miss), 0);
        ctl_ready = 1'b1;
        step(3);
        chk("rst_no_ack", {30'd0, wr_ack, rd_ack}, 0);
        rd_addr = 25'h0F0F0F0;
        rd_req  = 1'b1;
        push(CMD_WRITE, 25'h1555555, 16'hA5A5);
        push(CMD_READ, 25'h0F0F0F0, '0);
        reset_n = 1'b1;
        wait_q(1, 20, "post_rst_wr_timeout");
        wr_req = 1'b0;
        wait_q(0, 20, "post_rst_rd_timeout");
        rd_req = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
